// File: rtl/adder_8_multibyte_seq_pkg.sv
// rtl/adder_8_multibyte_seq_pkg.sv - shared state encoding and widths for the multibyte adder sequencer
package adder_8_multibyte_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte index needs at least one bit even for a single-byte operand.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/adder_8_structure.sv
// rtl/adder_8_structure.sv - purely combinational 8-bit ripple-carry adder
module adder_8_structure (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       out
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign out = c[8];

endmodule

// File: rtl/adder_8_multibyte_seq.sv
// rtl/adder_8_multibyte_seq.sv - feeds an 8-bit adder one byte per cycle to add/subtract wide operands
module adder_8_multibyte_seq
    import adder_8_multibyte_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic                    cin_in,
    input  logic [8*NBYTES-1:0]     op_a,
    input  logic [8*NBYTES-1:0]     op_b,
    output logic                    busy,
    output logic                    done,
    output logic [8*NBYTES-1:0]     result,
    output logic                    cout
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               sub_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  sum;
    logic               add_out;

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 comes from the carry preset at start.
    adder_8_structure u_adder (
        .a   (a_byte),
        .b   (sub_q ? ~b_byte : b_byte),
        .cin (carry),
        .sum (sum),
        .out (add_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (idx == LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        sub_q <= sub;
                        carry <= sub ? 1'b1 : cin_in;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            result[i*BYTE_W +: BYTE_W] <= sum;
                        end
                    end
                    carry <= add_out;
                    if (idx == LAST) begin
                        cout <= add_out;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_adder_8_multibyte_seq.sv
// tb/tb_adder_8_multibyte_seq.sv - randomized self-checking bench for the multibyte adder sequencer
module tb_adder_8_multibyte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin_in;
    logic [31:0] op_a, op_b, result;
    logic        busy, done, cout;

    logic        start1, sub1, cin1;
    logic [7:0]  a1, b1, result1;
    logic        busy1, done1, cout1;

    int vectors = 0;
    int errors  = 0;

    adder_8_multibyte_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin_in(cin_in),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result), .cout(cout)
    );

    adder_8_multibyte_seq #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin_in(cin1),
        .op_a(a1), .op_b(b1), .busy(busy1), .done(done1), .result(result1), .cout(cout1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: wide unsigned arithmetic; for subtraction cout means "no borrow".
    function automatic logic [32:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic c);
        if (s) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic s, input logic c);
        if (s) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || busy1) && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                        output logic [31:0] r, output logic co, output int lat);
        wait_idle();
        op_a = a; op_b = b; sub = s; cin_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; sub = 1'($urandom); cin_in = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 20);
        r = result; co = cout;
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                        output logic [7:0] r, output logic co, output int lat);
        wait_idle();
        a1 = a; b1 = b; sub1 = s; cin1 = c; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom); cin1 = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done1 && lat < 20);
        r = result1; co = cout1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start1 = 1'b1;
        op_a = 32'hDEADBEEF; op_b = 32'h01234567; sub = 1'b0; cin_in = 1'b1;
        a1 = 8'h5A; b1 = 8'hA5; sub1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        vectors++; if (result1 !== 8'h0) begin errors++; $display("FAIL reset_result1: got %h expected 00", result1); end
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy got %b expected 0", busy); end
        vectors++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_start_ignored1: busy got %b expected 0", busy1); end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h12345678, 32'h00000005, 32'h00010000, 32'h00010000};
        logic [31:0] tb [6] = '{32'h00000001, 32'h00000000, 32'h9ABCDEF0, 32'h00000007, 32'h00000001, 32'h00000001};
        logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] er [6] = '{32'h00000100, 32'h00000000, 32'hACF13568, 32'hFFFFFFFE, 32'h0000FFFF, 32'h0000FFFF};
        logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] r;
        logic        co;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run4(ta[i], tb[i], ts[i], tc[i], r, co, lat);
            vectors++; if (lat !== 4) begin errors++; $display("FAIL directed_latency[%0d]: got %0d edges expected 4", i, lat); end
            vectors++; if (r !== er[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, r, er[i]); end
            vectors++; if (co !== ec[i]) begin errors++; $display("FAIL directed_cout[%0d]: got %b expected %b", i, co, ec[i]); end
            @(posedge clk); #1;
            vectors++; if (done !== 1'b0) begin errors++; $display("FAIL directed_done_width[%0d]: got %b expected 0", i, done); end
            vectors++; if (result !== er[i]) begin errors++; $display("FAIL directed_hold[%0d]: got %h expected %h", i, result, er[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic        s, c, co;
        logic [32:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom); c = 1'($urandom);
            if (i % 8 == 0) b = a;
            exp = model32(a, b, s, c);
            run4(a, b, s, c, r, co, lat);
            vectors++; if (lat !== 4) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 4", i, lat); end
            vectors++; if ({co, r} !== exp) begin errors++; $display("FAIL random[%0d] a=%h b=%h sub=%b cin=%b: got %b_%h expected %b_%h", i, a, b, s, c, co, r, exp[32], exp[31:0]); end
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] a, b;
        logic [32:0] exp;
        logic [32:0] got = '0;
        int          ndone = 0;
        a = $urandom; b = $urandom;
        exp = model32(a, b, 1'b0, 1'b1);
        wait_idle();
        op_a = a; op_b = b; sub = 1'b0; cin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        op_a = ~a; op_b = a; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                got = {cout, result};
            end
        end
        vectors++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_count: got %0d done pulses expected 1", ndone); end
        vectors++; if (got !== exp) begin errors++; $display("FAIL busy_start_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_start_held();
        logic [31:0] a, b;
        logic [32:0] exp;
        int cyc = 0, first = -1, second = -1, cnt = 0;
        a = $urandom; b = $urandom;
        exp = model32(a, b, 1'b1, 1'b0);
        wait_idle();
        op_a = a; op_b = b; sub = 1'b1; cin_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                cnt++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        start = 1'b0;
        vectors++; if (second - first !== 6) begin errors++; $display("FAIL held_period: got %0d expected 6", second - first); end
        vectors++; if (cnt !== 3) begin errors++; $display("FAIL held_count: got %0d expected 3", cnt); end
        vectors++; if ({cout, result} !== exp) begin errors++; $display("FAIL held_result: got %b_%h expected %b_%h", cout, result, exp[32], exp[31:0]); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] a, b, r;
        logic        co;
        logic [32:0] exp;
        int          lat;
        int          ndone = 0;
        wait_idle();
        op_a = 32'h89ABCDEF; op_b = 32'h76543210; sub = 1'b0; cin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        vectors++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h expected 00000000", result); end
        vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b expected 0", cout); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        vectors++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", ndone); end
        a = $urandom; b = $urandom;
        exp = model32(a, b, 1'b0, 1'b0);
        run4(a, b, 1'b0, 1'b0, r, co, lat);
        vectors++; if (lat !== 4) begin errors++; $display("FAIL midrst_fresh_latency: got %0d expected 4", lat); end
        vectors++; if ({co, r} !== exp) begin errors++; $display("FAIL midrst_fresh: got %b_%h expected %b_%h", co, r, exp[32], exp[31:0]); end
    endtask

    task automatic test_nbytes1();
        logic [7:0] a, b, r;
        logic       s, c, co;
        logic [8:0] exp;
        int         lat;
        run1(8'hFF, 8'h01, 1'b0, 1'b0, r, co, lat);
        vectors++; if (lat !== 1) begin errors++; $display("FAIL nb1_latency: got %0d expected 1", lat); end
        vectors++; if (r !== 8'h00) begin errors++; $display("FAIL nb1_result: got %h expected 00", r); end
        vectors++; if (co !== 1'b1) begin errors++; $display("FAIL nb1_cout: got %b expected 1", co); end
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
            exp = model8(a, b, s, c);
            run1(a, b, s, c, r, co, lat);
            vectors++; if (lat !== 1) begin errors++; $display("FAIL nb1_random_latency[%0d]: got %0d expected 1", i, lat); end
            vectors++; if ({co, r} !== exp) begin errors++; $display("FAIL nb1_random[%0d] a=%h b=%h sub=%b cin=%b: got %b_%h expected %b_%h", i, a, b, s, c, co, r, exp[8], exp[7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_start_held();
        test_reset_mid_run();
        test_nbytes1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
